// File: rtl/uart_rx.sv
// 8N1 UART receiver with an AXI4-Stream master output.
// Bit period is 8*prescale clk cycles, matching the transmitter's prescale convention.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [3:0] BITS = 4'(DATA_WIDTH);

  state_t                  state_reg, state_next;
  logic                    rxd_meta_reg, rxd_s_reg;
  logic [15:0]             p_reg, p_next;
  logic [15:0]             p_eff;
  logic [18:0]             cnt_reg, cnt_next;
  logic [3:0]              bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [DATA_WIDTH-1:0]   tdata_reg, tdata_next;
  logic                    tvalid_reg, tvalid_next;
  logic                    busy_reg, busy_next;
  logic                    overrun_reg, overrun_next;
  logic                    frame_err_reg, frame_err_next;
  logic                    word_done;
  logic [18:0]             full_bit, half_bit;

  assign p_eff    = (prescale == 16'd0) ? 16'd1 : prescale;
  assign half_bit = {1'b0, p_eff, 2'b00} - 19'd1;
  assign full_bit = {p_reg, 3'b000} - 19'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_reg  <= 1'b1;
      rxd_s_reg     <= 1'b1;
      state_reg     <= IDLE;
      p_reg         <= 16'd1;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rxd_meta_reg  <= rxd;
      rxd_s_reg     <= rxd_meta_reg;
      state_reg     <= state_next;
      p_reg         <= p_next;
      cnt_reg       <= cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tdata_reg     <= tdata_next;
      tvalid_reg    <= tvalid_next;
      busy_reg      <= busy_next;
      overrun_reg   <= overrun_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    p_next         = p_reg;
    cnt_next       = cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    tdata_next     = tdata_reg;
    tvalid_next    = tvalid_reg && !m_axis_tready;
    busy_next      = busy_reg;
    overrun_next   = 1'b0;
    frame_err_next = 1'b0;
    word_done      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rxd_s_reg) begin
          p_next     = p_eff;
          cnt_next   = half_bit;
          busy_next  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 19'd1;
        end else if (rxd_s_reg) begin
          // Line went back high by mid-start: treat as a glitch, silently.
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next     = full_bit;
          bit_cnt_next = BITS;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 19'd1;
        end else begin
          shift_next   = {rxd_s_reg, shift_reg[DATA_WIDTH-1:1]};
          cnt_next     = full_bit;
          bit_cnt_next = bit_cnt_reg - 4'd1;
          if (bit_cnt_reg == 4'd1) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 19'd1;
        end else begin
          busy_next = 1'b0;
          if (rxd_s_reg) begin
            word_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_s_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A completed word always wins the output register; it is an overrun only
    // if the previous word was still pending and not taken this cycle.
    if (word_done) begin
      tdata_next   = shift_reg;
      tvalid_next  = 1'b1;
      overrun_next = tvalid_reg && !m_axis_tready;
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign busy          = busy_reg;
  assign overrun_error = overrun_reg;
  assign frame_error   = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// checked against a queue of expected words built from the bytes sent.
module tb_uart_rx;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rxd = 1'b1;
  logic          tready = 1'b0;
  logic [15:0]   prescale = 16'd1;
  logic [DW-1:0] tdata;
  logic          tvalid, busy, ov, fe;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (ov),
    .frame_error   (fe),
    .prescale      (prescale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, rise_cnt = 0, xfer_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected words are queued when a good frame starts; every transfer pops one,
  // and an overrun discards the oldest pending word.
  task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input int p, input bit wiggle);
    int bt;
    bt = 8 * ((p == 0) ? 1 : p);
    prescale = 16'(p);
    if (stop_ok) exp_q.push_back(d);
    rxd = 1'b0;
    fall_cyc = cyc;
    tick(bt);
    if (wiggle) prescale = 16'($urandom_range(1, 5));
    for (int i = 0; i < DW; i++) begin
      rxd = d[i];
      tick(bt);
    end
    rxd = stop_ok;
    tick(bt);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Compare process: runs on every falling edge.
  initial begin
    logic          pv, pr;
    logic [DW-1:0] pd;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (tvalid && !pv) begin
          rise_cnt++;
          rise_cyc = cyc;
        end
        if (fe) fe_cnt++;
        if (ov) begin
          ov_cnt++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (pv && !pr && tvalid && !ov) check("tdata_hold", tdata, pd);
        if (tvalid && tready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", tdata, cyc);
          end else begin
            check("tdata", tdata, exp_q.pop_front());
          end
        end
      end
      pv = tvalid; pr = tready; pd = tdata;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rise, b_fe, b_ov, b_x, lat, p, gap;
    logic [DW-1:0] d;

    // Reset state
    #2 rst_n = 1'b0;
    tick(3);
    check("rst_tdata", tdata, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_ov", ov, 0);
    check("rst_fe", fe, 0);
    rst_n = 1'b1;
    tready = 1'b1;
    tick(5);

    // Single frame at prescale 1, latency pinned by hand: 2+4+64+8 to the stop sample, +1
    b_rise = rise_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
    fork
      send_frame(8'h55, 1'b1, 1, 1'b0);
      begin
        repeat (40) @(negedge clk);
        check("busy_mid_frame", busy, 1);
      end
    join
    tick(20);
    lat = rise_cyc - fall_cyc - 1;
    $display("frame 0x55 latency %0d cycles", lat);
    check("latency_in_window", (lat >= 78 && lat <= 80) ? 1 : 0, 1);
    check("words_0x55", rise_cnt - b_rise, 1);
    check("tvalid_pulse", tvalid, 0);
    check("no_err_fe", fe_cnt - b_fe, 0);
    check("no_err_ov", ov_cnt - b_ov, 0);
    check("busy_idle", busy, 0);
    drain("queue_0x55", 10);

    // Back-to-back at prescale 4
    b_rise = rise_cnt;
    send_frame(8'hA3, 1'b1, 4, 1'b0);
    send_frame(8'h0F, 1'b1, 4, 1'b0);
    tick(40);
    check("words_b2b", rise_cnt - b_rise, 2);
    drain("queue_b2b", 10);

    // Overrun with tready low
    tready = 1'b0;
    b_ov = ov_cnt; b_x = xfer_cnt;
    send_frame(8'h11, 1'b1, 1, 1'b0);
    send_frame(8'h22, 1'b1, 1, 1'b0);
    tick(20);
    check("ovr_tvalid", tvalid, 1);
    check("ovr_tdata", tdata, 8'h22);
    check("ovr_pulses", ov_cnt - b_ov, 1);
    tready = 1'b1;
    tick(3);
    check("ovr_xfer", xfer_cnt - b_x, 1);
    check("ovr_tvalid_clear", tvalid, 0);
    drain("queue_ovr", 10);

    // Framing error followed by a long break
    b_rise = rise_cnt; b_fe = fe_cnt;
    send_frame(8'h3C, 1'b0, 1, 1'b0);
    tick(40 * 8);
    check("fe_pulses", fe_cnt - b_fe, 1);
    check("fe_no_word", rise_cnt - b_rise, 0);
    check("fe_busy_in_break", busy, 0);
    rxd = 1'b1;
    tick(20);
    send_frame(8'h7E, 1'b1, 1, 1'b0);
    tick(20);
    check("after_break_word", rise_cnt - b_rise, 1);
    drain("queue_7e", 10);

    // Start-bit glitch at prescale 2
    b_rise = rise_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
    prescale = 16'd2;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    @(negedge clk);
    check("glitch_busy_rise", busy, 1);
    tick(20);
    check("glitch_busy_fall", busy, 0);
    check("glitch_no_word", rise_cnt - b_rise, 0);
    check("glitch_no_fe", fe_cnt - b_fe, 0);
    check("glitch_no_ov", ov_cnt - b_ov, 0);

    // Reset in the middle of a frame, with a stale word pending
    tready = 1'b0;
    send_frame(8'h5A, 1'b1, 1, 1'b0);
    tick(15);
    check("pre_rst_pending", tvalid, 1);
    prescale = 16'd1;
    rxd = 1'b0;
    tick(8);
    rxd = 1'b1;
    tick(24);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_tdata", tdata, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tready = 1'b1;
    tick(10);
    b_rise = rise_cnt;
    send_frame(8'h81, 1'b1, 1, 1'b0);
    tick(20);
    check("post_rst_word", rise_cnt - b_rise, 1);
    drain("queue_81", 10);

    // Randomized frames: random prescale (incl. 0), data, gaps, mid-frame prescale changes, tready
    b_fe = fe_cnt; b_ov = ov_cnt; b_x = xfer_cnt;
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      p = $urandom_range(0, 3);
      d = DW'($urandom);
      send_frame(d, 1'b1, p, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 15);
      if (gap > 0) tick(gap);
    end
    drain("queue_random", 500);
    rand_ready = 1'b0;
    tick(2);
    tready = 1'b1;
    check("rand_xfers", xfer_cnt - b_x, 25);
    check("rand_no_fe", fe_cnt - b_fe, 0);
    check("rand_no_ov", ov_cnt - b_ov, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
